// File: rtl/trace_buffer.sv
// Circular trace memory: captures packed vectors while tracing is active,
// then drains them oldest-first over a valid/ready readout port.
module trace_buffer #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int BUFFER_SIZE        = 8,
    parameter int PERSONAL_CONFIG_ID = 0
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              tracing,
    input  logic                              valid_in,
    input  logic [N-1:0][DATA_WIDTH-1:0]      vector_in,
    input  logic [7:0]                        configId,
    input  logic [7:0]                        configData,
    input  logic                              ready_in,
    output logic [N-1:0][DATA_WIDTH-1:0]      vector_out,
    output logic                              valid_out,
    output logic [$clog2(BUFFER_SIZE):0]      word_count,
    output logic                              overflow,
    output logic                              draining
);

    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(BUFFER_SIZE);
    localparam logic [7:0] MY_ID = 8'(PERSONAL_CONFIG_ID);

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;
    typedef enum logic [1:0] {IDLE, TRACE, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          mode;
    logic [7:0]    byte_counter;
    vec_t          mem [BUFFER_SIZE];

    logic          start;
    logic          full;
    logic          wr_req;
    logic          mem_we;
    logic [AW-1:0] base_ptr;
    logic [CW-1:0] base_cnt;
    logic          base_ovf;
    logic [AW-1:0] nxt_ptr;
    logic [CW-1:0] nxt_cnt;
    logic          nxt_ovf;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_nxt;
    logic          unused_cfg;

    assign unused_cfg = ^configData[7:1];
    assign draining   = (state == DRAIN);

    // A session start rebases the write bookkeeping before this cycle's write.
    always_comb begin
        start    = tracing && (state != TRACE);
        base_ptr = start ? '0 : wr_ptr;
        base_cnt = start ? '0 : word_count;
        base_ovf = start ? 1'b0 : overflow;
        full     = (base_cnt == FULL);
        wr_req   = tracing && valid_in;
        mem_we   = wr_req && !(mode && full);
        nxt_ptr  = mem_we ? base_ptr + 1'b1 : base_ptr;
        nxt_cnt  = (mem_we && !full) ? base_cnt + 1'b1 : base_cnt;
        nxt_ovf  = base_ovf | (wr_req && full);
        oldest   = wr_ptr - word_count[AW-1:0];
        rd_nxt   = rd_ptr + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[base_ptr] <= vector_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            word_count   <= '0;
            overflow     <= 1'b0;
            valid_out    <= 1'b0;
            vector_out   <= '0;
            mode         <= 1'b0;
            byte_counter <= '0;
        end else if (tracing) begin
            state      <= TRACE;
            wr_ptr     <= nxt_ptr;
            word_count <= nxt_cnt;
            overflow   <= nxt_ovf;
            if (start) begin
                valid_out <= 1'b0;
            end
        end else begin
            if (configId == MY_ID) begin
                if (byte_counter == 8'd0) begin
                    mode <= configData[0];
                end
                if (byte_counter != 8'hFF) begin
                    byte_counter <= byte_counter + 8'd1;
                end
            end else begin
                byte_counter <= '0;
            end
            unique case (state)
                TRACE: begin
                    if (word_count != '0) begin
                        state      <= DRAIN;
                        rd_ptr     <= oldest;
                        vector_out <= mem[oldest];
                        valid_out  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (valid_out && ready_in) begin
                        word_count <= word_count - 1'b1;
                        rd_ptr     <= rd_nxt;
                        if (word_count == CW'(1)) begin
                            valid_out <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            vector_out <= mem[rd_nxt];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_buffer.sv
// Randomised and directed bench for trace_buffer with a queue-based
// reference model and a decoupled readout scoreboard.
module tb_trace_buffer;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int BS = 8;
    localparam logic [7:0] PID = 8'd0;
    localparam logic [7:0] OTHER = 8'hFF;

    typedef logic [N-1:0][DW-1:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 tracing;
    logic                 valid_in;
    vec_t                 vector_in;
    logic [7:0]           configId;
    logic [7:0]           configData;
    logic                 ready_in;
    vec_t                 vector_out;
    logic                 valid_out;
    logic [$clog2(BS):0]  word_count;
    logic                 overflow;
    logic                 draining;

    trace_buffer #(
        .N(N), .DATA_WIDTH(DW), .BUFFER_SIZE(BS), .PERSONAL_CONFIG_ID(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .tracing(tracing),
        .valid_in(valid_in), .vector_in(vector_in),
        .configId(configId), .configData(configData),
        .ready_in(ready_in), .vector_out(vector_out),
        .valid_out(valid_out), .word_count(word_count),
        .overflow(overflow), .draining(draining)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stored vectors oldest-first, plus session flags.
    vec_t mq[$];
    vec_t exp_q[$];
    bit   m_sess, m_drain, m_ovf, m_mode;
    int   m_bc;

    function automatic vec_t lanes(int v);
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = DW'(v);
        return r;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t r;
        for (int i = 0; i < N; i++) r[i] = $urandom();
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    function automatic void model_update();
        if (!reset_n) begin
            mq.delete(); exp_q.delete();
            m_sess = 0; m_drain = 0; m_ovf = 0; m_mode = 0; m_bc = 0;
        end else if (tracing) begin
            if (!m_sess) begin
                mq.delete(); exp_q.delete();
                m_sess = 1; m_drain = 0; m_ovf = 0;
            end
            if (valid_in) begin
                if (mq.size() == BS) begin
                    m_ovf = 1;
                    if (!m_mode) begin
                        void'(mq.pop_front());
                        mq.push_back(vector_in);
                    end
                end else begin
                    mq.push_back(vector_in);
                end
            end
        end else begin
            if (configId == PID) begin
                if (m_bc == 0) m_mode = configData[0];
                if (m_bc < 255) m_bc++;
            end else begin
                m_bc = 0;
            end
            if (m_sess) begin
                m_sess = 0;
                if (mq.size() > 0) begin
                    m_drain = 1;
                    foreach (mq[i]) exp_q.push_back(mq[i]);
                end
            end else if (m_drain && ready_in) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_drain = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        chk("word_count", 64'(word_count), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("valid_out", 64'(valid_out), 64'(m_drain));
        chk("draining", 64'(draining), 64'(m_drain));
    endtask

    // Readout scoreboard: compares every accepted vector and stall stability.
    initial begin
        bit   stall;
        vec_t held;
        vec_t e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (reset_n && valid_out) begin
                if (stall) begin
                    checks++;
                    if (vector_out !== held) begin
                        errors++;
                        $display("FAIL hold got %h exp %h", vector_out, held);
                    end
                end
                if (!tracing && ready_in) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL xfer got %h exp none", vector_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (vector_out !== e) begin
                            errors++;
                            $display("FAIL xfer got %h exp %h", vector_out, e);
                        end
                    end
                    stall = 0;
                end else if (!tracing) begin
                    stall = 1;
                    held = vector_out;
                end else begin
                    stall = 0;
                end
            end else begin
                stall = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic session(int n, bit rnd);
        tracing = 1;
        for (int i = 0; i < n; i++) begin
            valid_in = 1;
            vector_in = rnd ? rnd_vec() : lanes(i + 1);
            tick();
        end
        valid_in = 0;
    endtask

    task automatic drain(int n);
        tracing = 0;
        ready_in = 1;
        repeat (n) tick();
    endtask

    task automatic cfg(logic [7:0] d);
        tracing = 0;
        configId = PID;
        configData = d;
        tick();
        configId = OTHER;
    endtask

    initial begin
        bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
        reset_n = 0; tracing = 0; valid_in = 0; vector_in = '0;
        configId = OTHER; configData = 0; ready_in = 0;
        tick(); tick();
        chk("reset_vec", 64'(|vector_out), 64'd0);
        reset_n = 1;
        tick();

        // basic capture and drain
        session(3, 0);
        drain(6);
        chk("basic_empty", 64'(exp_q.size()), 64'd0);

        // circular wrap
        session(11, 0);
        drain(11);

        // stop-when-full
        cfg(8'h01);
        session(11, 0);
        drain(11);

        // second config byte ignored
        configId = PID; configData = 8'h01; tracing = 0; tick();
        configData = 8'h00; tick();
        configId = OTHER;
        session(11, 0);
        drain(11);

        // foreign id ignored
        cfg(8'h00);
        configId = 8'd5; configData = 8'h01; tick();
        configId = OTHER;
        session(11, 0);
        drain(11);

        // config while tracing ignored
        configId = PID; configData = 8'h01;
        session(11, 1);
        configId = OTHER;
        drain(11);

        // backpressure
        session(4, 1);
        tracing = 0;
        foreach (pat[i]) begin
            ready_in = pat[i];
            tick();
        end
        drain(4);

        // abort mid-drain, with and without a same-cycle write
        for (int v = 0; v < 2; v++) begin
            session(5, 1);
            drain(3);
            tracing = 1; valid_in = v[0]; vector_in = lanes(99);
            tick();
            valid_in = 0;
            tick();
            drain(BS + 2);
        end

        // reset mid-trace clears mode back to circular
        cfg(8'h01);
        session(3, 1);
        tracing = 1; valid_in = 1; reset_n = 0;
        tick();
        chk("rst_vec", 64'(|vector_out), 64'd0);
        reset_n = 1; tracing = 0; valid_in = 0;
        tick();
        session(11, 0);
        drain(11);

        // random traffic
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(11) == 0) tracing = ~tracing;
            valid_in   = ($urandom_range(3) != 0);
            vector_in  = rnd_vec();
            ready_in   = ($urandom_range(2) != 0);
            configId   = ($urandom_range(5) == 0) ? PID : OTHER;
            configData = 8'($urandom());
            reset_n    = ($urandom_range(199) != 0);
            tick();
        end
        reset_n = 1; configId = OTHER; valid_in = 0;
        drain(BS + 3);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
